// File: rtl/bcd_pkg.sv
// Shared widths, digit type and range check for the binary-to-BCD converter.
package bcd_pkg;

   localparam int BCD_BIN_W  = 12;
   localparam int BCD_DIGITS = 4;

   typedef logic [3:0] bcd_digit_t;

   // True when DIGITS decimal digits can hold every BIN_W-bit value.
   function automatic bit bcd_range_ok(input int bin_w, input int digits);
      longint unsigned p10;
      longint unsigned max_v;
      p10 = 1;
      for (int i = 0; i < digits; i++) p10 = p10 * 10;
      max_v = (64'd1 << bin_w) - 64'd1;
      return p10 > max_v;
   endfunction

endpackage

// File: rtl/bin_to_bcd_core.sv
// Combinational double-dabble (shift-add-3) binary-to-BCD core.
module bin_to_bcd_core
   import bcd_pkg::*;
#(
   parameter int BIN_W  = BCD_BIN_W,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic [BIN_W-1:0]    i_bin,
   output logic [4*DIGITS-1:0] o_bcd
);

   logic [4*DIGITS-1:0] bcd;
   bcd_digit_t          dig;

   always_comb begin
      bcd = '0;
      dig = '0;
      for (int i = BIN_W - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS; d++) begin
            dig = bcd[4*d +: 4];
            if (dig >= 4'd5) bcd[4*d +: 4] = dig + 4'd3;
         end
         bcd = {bcd[4*DIGITS-2:0], i_bin[i]};
      end
      o_bcd = bcd;
   end

endmodule

// File: rtl/bin_to_bcd.sv
// Registered binary-to-BCD converter with optional leading-zero blank flags.
// Blank flags are generated only when BIN_TO_BCD_BLANK_EN is defined.
module bin_to_bcd
   import bcd_pkg::*;
#(
   parameter int BIN_W  = BCD_BIN_W,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic [BIN_W-1:0]    i_bin,
   output logic                o_valid,
   output logic [4*DIGITS-1:0] o_bcd,
   output logic [DIGITS-1:0]   o_blank
);

   if (!bcd_range_ok(BIN_W, DIGITS)) begin : g_range_bad
      $error("bin_to_bcd: DIGITS too small for BIN_W");
   end

   logic [4*DIGITS-1:0] conv;
   logic [4*DIGITS-1:0] bcd_d, bcd_q;
   logic                valid_d, valid_q;

   bin_to_bcd_core #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_core (
      .i_bin (i_bin),
      .o_bcd (conv)
   );

   always_comb begin
      bcd_d   = bcd_q;
      valid_d = i_valid;
      if (i_valid) bcd_d = conv;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
      end
   end

   assign o_bcd   = bcd_q;
   assign o_valid = valid_q;

`ifdef BIN_TO_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_d, blank_q;
   logic              zero_above;

   // Scan from the top digit down; digit 0 is never blanked.
   always_comb begin
      blank_d    = blank_q;
      zero_above = 1'b1;
      if (i_valid) begin
         blank_d = '0;
         for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above & (conv[4*k +: 4] == 4'd0);
            blank_d[k] = zero_above;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) blank_q <= '0;
      else     blank_q <= blank_d;
   end

   assign o_blank = blank_q;
`else
   assign o_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed, boundary, hold, reset and exhaustive.
module tb_bin_to_bcd;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  blank;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [11:0] i_bin = '0;
   logic        o_valid;
   logic [15:0] o_bcd;
   logic [3:0]  o_blank;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   bin_to_bcd #(.BIN_W(12), .DIGITS(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_bin   (i_bin),
      .o_valid (o_valid),
      .o_bcd   (o_bcd),
      .o_blank (o_blank)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input int v);
      exp_t r;
      int   p;
      r = '0;
      p = 1;
      for (int k = 0; k < 4; k++) begin
         r.bcd[4*k +: 4] = 4'((v / p) % 10);
`ifdef BIN_TO_BCD_BLANK_EN
         if (k > 0 && v < p) r.blank[k] = 1'b1;
`endif
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] blank_of(input logic [3:0] b);
`ifdef BIN_TO_BCD_BLANK_EN
      return b;
`else
      return 4'b0000 & b;
`endif
   endfunction

   function automatic exp_t pop_exp();
      exp_t e;
      e = '1;
      if (sb.size() != 0) e = sb.pop_front();
      return e;
   endfunction

   task automatic drive(input logic r, input logic v, input logic [11:0] b);
      rst     = r;
      i_valid = v;
      i_bin   = b;
      if (!r && v) sb.push_back(model(int'(b)));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 12'd123);
      drive(1'b1, 1'b1, 12'd123);
      checks++;
      if (o_bcd !== 16'h0000 || o_valid !== 1'b0 || o_blank !== 4'b0000) begin
         errors++;
         $display("FAIL reset: bcd=%h valid=%b blank=%b want 0000/0/0000",
                  o_bcd, o_valid, o_blank);
      end
   endtask

   task automatic test_directed();
      logic [11:0] vals [9];
      logic [15:0] bcds [9];
      logic [3:0]  blks [9];
      exp_t        e;
      vals = '{12'd123, 12'd255, 12'd999, 12'd15, 12'd0,
               12'd4095, 12'd1000, 12'd9, 12'd10};
      bcds = '{16'h0123, 16'h0255, 16'h0999, 16'h0015, 16'h0000,
               16'h4095, 16'h1000, 16'h0009, 16'h0010};
      blks = '{4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1110,
               4'b0000, 4'b0000, 4'b1110, 4'b1100};
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, vals[i]);
         e = pop_exp();
         checks++;
         if (o_valid !== 1'b1 || o_bcd !== bcds[i] || o_blank !== blank_of(blks[i])
             || e.bcd !== bcds[i] || e.blank !== blank_of(blks[i])) begin
            errors++;
            $display("FAIL directed %0d: valid=%b bcd=%h blank=%b want 1/%h/%b",
                     vals[i], o_valid, o_bcd, o_blank, bcds[i], blank_of(blks[i]));
         end
      end
   endtask

   task automatic test_hold();
      exp_t e;
      drive(1'b0, 1'b1, 12'd255);
      e = pop_exp();
      checks++;
      if (o_valid !== 1'b1 || o_bcd !== e.bcd || o_blank !== e.blank) begin
         errors++;
         $display("FAIL hold_load: valid=%b bcd=%h want 1/%h", o_valid, o_bcd, e.bcd);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 12'd7);
         checks++;
         if (o_valid !== 1'b0 || o_bcd !== 16'h0255 || o_blank !== blank_of(4'b1000)) begin
            errors++;
            $display("FAIL hold %0d: valid=%b bcd=%h blank=%b want 0/0255/%b",
                     i, o_valid, o_bcd, o_blank, blank_of(4'b1000));
         end
      end
   endtask

   task automatic test_reset_priority();
      drive(1'b1, 1'b1, 12'd4095);
      checks++;
      if (o_bcd !== 16'h0000 || o_valid !== 1'b0 || o_blank !== 4'b0000) begin
         errors++;
         $display("FAIL rst_prio: bcd=%h valid=%b blank=%b want 0000/0/0000",
                  o_bcd, o_valid, o_blank);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int v = 1; v <= 3; v++) begin
         drive(1'b0, 1'b1, 12'(v));
         e = pop_exp();
         checks++;
         if (o_valid !== 1'b1 || o_bcd !== 16'(v) || o_bcd !== e.bcd || o_blank !== e.blank) begin
            errors++;
            $display("FAIL b2b %0d: valid=%b bcd=%h want 1/%h", v, o_valid, o_bcd, e.bcd);
         end
      end
      drive(1'b0, 1'b0, 12'd0);
      checks++;
      if (o_valid !== 1'b0 || o_bcd !== 16'h0003) begin
         errors++;
         $display("FAIL b2b_end: valid=%b bcd=%h want 0/0003", o_valid, o_bcd);
      end
   endtask

   task automatic test_exhaustive();
      exp_t e;
      for (int v = 0; v < 4096; v++) begin
         drive(1'b0, 1'b1, 12'(v));
         e = pop_exp();
         checks++;
         if (o_valid !== 1'b1 || o_bcd !== e.bcd || o_blank !== e.blank) begin
            errors++;
            $display("FAIL exh %0d: valid=%b bcd=%h blank=%b want 1/%h/%b",
                     v, o_valid, o_bcd, o_blank, e.bcd, e.blank);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_priority();
      test_back_to_back();
      test_exhaustive();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d left want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
